// File: rtl/adder_64.sv
// adder_64: registered 64-bit adder with carry-in, carry-out and signed overflow.
// Two-level carry-lookahead (per-group G/P, then group carries) feeding one output register.
module adder_64 #(
    parameter int WIDTH = 64,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NG-1:0]    w_grp_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate/propagate from the bit-level g/p of each GROUP-bit slice.
    always_comb begin : grp_gp
        logic v_gg;
        logic v_pp;
        w_grp_g = '0;
        w_grp_p = '0;
        for (int gi = 0; gi < NG; gi++) begin
            v_gg = 1'b0;
            v_pp = 1'b1;
            for (int k = GROUP - 1; k >= 0; k--) begin
                v_gg = v_gg | (v_pp & w_g[gi*GROUP+k]);
                v_pp = v_pp & w_p[gi*GROUP+k];
            end
            w_grp_g[gi] = v_gg;
            w_grp_p[gi] = v_pp;
        end
    end

    // Second-level lookahead: each group carry-in as a flat sum of products.
    always_comb begin : grp_carry
        logic v_cc;
        logic v_pp;
        w_gc = '0;
        for (int i = 0; i <= NG; i++) begin
            v_cc = 1'b0;
            v_pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                v_cc = v_cc | (v_pp & w_grp_g[j]);
                v_pp = v_pp & w_grp_p[j];
            end
            w_gc[i] = v_cc | (v_pp & c_in);
        end
    end

    // Bit carries inside each group, expanded from the group carry-in.
    always_comb begin : bit_carry
        logic v_cc;
        logic v_pp;
        w_c = '0;
        for (int gi = 0; gi < NG; gi++) begin
            for (int k = 0; k < GROUP; k++) begin
                v_cc = 1'b0;
                v_pp = 1'b1;
                for (int j = k - 1; j >= 0; j--) begin
                    v_cc = v_cc | (v_pp & w_g[gi*GROUP+j]);
                    v_pp = v_pp & w_p[gi*GROUP+j];
                end
                w_c[gi*GROUP+k] = v_cc | (v_pp & w_gc[gi]);
            end
        end
    end

    assign w_sum  = w_p ^ w_c;
    assign w_cout = w_gc[NG];
    assign w_ovf  = w_c[WIDTH-1] ^ w_gc[NG];

    // Output register: loads every cycle; reset clears data, flags and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_valid <= in_valid;
        end
    end

    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign overflow  = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_adder_64.sv
// tb_adder_64: scoreboard bench for adder_64.
// Expectations are queued at drive time and popped one cycle later.
module tb_adder_64;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;
    logic        out_valid;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    adder_64 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: 65-bit add and the sign rule, independent of carries.
    function automatic exp_t model(input logic [63:0] ta, input logic [63:0] tb,
                                   input logic tc, input logic tv, input logic tr);
        logic [64:0] full;
        exp_t e;
        full = {1'b0, ta} + {1'b0, tb} + {64'd0, tc};
        if (tr) begin
            e = '0;
        end else begin
            e.s  = full[63:0];
            e.co = full[64];
            e.ov = (ta[63] == tb[63]) && (full[63] != ta[63]);
            e.v  = tv;
        end
        return e;
    endfunction

    task automatic drive(input logic [63:0] ta, input logic [63:0] tb,
                         input logic tc, input logic tv, input logic tr);
        @(negedge clk);
        a        = ta;
        b        = tb;
        c_in     = tc;
        in_valid = tv;
        rst      = tr;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1);
            q.push_back('0);
            @(posedge clk);
            #1;
            e = q.pop_front();
            total++;
            if ({sum, c_out, overflow, out_valid} !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got s=%h co=%b ov=%b v=%b exp s=%h co=%b ov=%b v=%b",
                         i, sum, c_out, overflow, out_valid, e.s, e.co, e.ov, e.v);
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta[4];
        logic [63:0] tb[4];
        logic        tc[4];
        exp_t        ex[4];
        exp_t        e;
        ta[0] = 64'd4096;                tb[0] = 64'hFFFF_FFFF_FFFF_FE2D; tc[0] = 1'b0;
        ex[0] = '{s: 64'd3629, co: 1'b1, ov: 1'b0, v: 1'b1};
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'd0;                  tc[1] = 1'b1;
        ex[1] = '{s: 64'd0, co: 1'b1, ov: 1'b0, v: 1'b1};
        ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'd1;                  tc[2] = 1'b0;
        ex[2] = '{s: 64'h8000_0000_0000_0000, co: 1'b0, ov: 1'b1, v: 1'b1};
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h8000_0000_0000_0000; tc[3] = 1'b0;
        ex[3] = '{s: 64'd0, co: 1'b1, ov: 1'b1, v: 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b1, 1'b0);
            q.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            total++;
            if ({sum, c_out, overflow, out_valid} !== e) begin
                bad++;
                $display("FAIL directed[%0d]: got s=%h co=%b ov=%b v=%b exp s=%h co=%b ov=%b v=%b",
                         i, sum, c_out, overflow, out_valid, e.s, e.co, e.ov, e.v);
            end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        logic [63:0] ta;
        logic [63:0] tb;
        ta = 64'h0123_4567_89AB_CDEF;
        tb = 64'hFEDC_BA98_7654_3210;
        drive(ta, tb, 1'b1, 1'b0, 1'b0);
        q.push_back('{s: 64'd0, co: 1'b1, ov: 1'b0, v: 1'b0});
        @(posedge clk);
        #1;
        e = q.pop_front();
        total++;
        if ({sum, c_out, overflow, out_valid} !== e) begin
            bad++;
            $display("FAIL invalid: got s=%h co=%b ov=%b v=%b exp s=%h co=%b ov=%b v=%b",
                     sum, c_out, overflow, out_valid, e.s, e.co, e.ov, e.v);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ta[3];
        logic [63:0] tb[3];
        logic        tc[3];
        logic        tr[3];
        exp_t        e;
        ta[0] = 64'd10;                  tb[0] = 64'd20;                  tc[0] = 1'b1; tr[0] = 1'b0;
        ta[1] = 64'hFFFF_0000_FFFF_0000; tb[1] = 64'h0001_FFFF_0001_FFFF; tc[1] = 1'b0; tr[1] = 1'b0;
        ta[2] = 64'h1111_2222_3333_4444; tb[2] = 64'h5555_6666_7777_8888; tc[2] = 1'b0; tr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b1, tr[i]);
            q.push_back(model(ta[i], tb[i], tc[i], 1'b1, tr[i]));
            @(posedge clk);
            #1;
            e = q.pop_front();
            total++;
            if ({sum, c_out, overflow, out_valid} !== e) begin
                bad++;
                $display("FAIL b2b[%0d]: got s=%h co=%b ov=%b v=%b exp s=%h co=%b ov=%b v=%b",
                         i, sum, c_out, overflow, out_valid, e.s, e.co, e.ov, e.v);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [63:0] ta;
        logic [63:0] tb;
        logic        tc;
        logic        tv;
        int          nbad;
        nbad = 0;
        for (int i = 0; i < 10000; i++) begin
            ta = {$urandom, $urandom};
            tb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) tb = ~ta;
            if ($urandom_range(0, 15) == 0) ta = 64'hFFFF_FFFF_FFFF_FFFF;
            tc = 1'($urandom_range(0, 1));
            tv = ($urandom_range(0, 9) != 0);
            drive(ta, tb, tc, tv, 1'b0);
            q.push_back(model(ta, tb, tc, tv, 1'b0));
            @(posedge clk);
            #1;
            e = q.pop_front();
            total++;
            if ({sum, c_out, overflow, out_valid} !== e) begin
                bad++;
                nbad++;
                if (nbad <= 10)
                    $display("FAIL random[%0d]: a=%h b=%h ci=%b got s=%h co=%b ov=%b v=%b exp s=%h co=%b ov=%b v=%b",
                             i, ta, tb, tc, sum, c_out, overflow, out_valid, e.s, e.co, e.ov, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_back_to_back();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
